// File: rtl/gamepad_pmod_rx.sv
// Gamepad Pmod serial receiver: synchronises the pins, shifts in a 12-bit frame
// and publishes a frame-checked button word. GAMEPAD_RX_WATCHDOG_EN adds a presence timeout.
module gamepad_pmod_rx #(
    parameter int TIMEOUT_W = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pmod_data,
    input  logic        pmod_clk,
    input  logic        pmod_latch,
    output logic [11:0] buttons,
    output logic        is_present,
    output logic        frame_valid,
    output logic        frame_err
);

    logic data_m, data_s;
    logic clk_m, clk_s, clk_d;
    logic latch_m, latch_s, latch_d;
    logic clk_rise, latch_rise;

    logic [11:0] shreg;
    logic [4:0]  bitcnt;
    logic        frame_ok;
    logic        wd_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_m  <= 1'b0;
            data_s  <= 1'b0;
            clk_m   <= 1'b0;
            clk_s   <= 1'b0;
            clk_d   <= 1'b0;
            latch_m <= 1'b0;
            latch_s <= 1'b0;
            latch_d <= 1'b0;
        end else begin
            data_m  <= pmod_data;
            data_s  <= data_m;
            clk_m   <= pmod_clk;
            clk_s   <= clk_m;
            clk_d   <= clk_s;
            latch_m <= pmod_latch;
            latch_s <= latch_m;
            latch_d <= latch_s;
        end
    end

    assign clk_rise   = clk_s & ~clk_d;
    assign latch_rise = latch_s & ~latch_d;
    assign frame_ok   = latch_rise && (bitcnt == 5'd12);

`ifdef GAMEPAD_RX_WATCHDOG_EN
    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;
    logic [TIMEOUT_W-1:0] wd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd <= '0;
        else if (frame_ok)
            wd <= '0;
        else if (wd != WD_MAX)
            wd <= wd + 1'b1;
    end

    // Asserted on the edge that brings the counter to its maximum, and while it sits there.
    assign wd_hit = (wd >= WD_MAX - 1'b1);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_W > 0);
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            bitcnt      <= '0;
            buttons     <= '0;
            is_present  <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (wd_hit) begin
                buttons    <= '0;
                is_present <= 1'b0;
            end
            // A latch edge wins over a coincident shift-clock edge, which is dropped.
            if (latch_rise) begin
                bitcnt <= '0;
                if (frame_ok) begin
                    frame_valid <= 1'b1;
                    if (shreg == 12'hFFF) begin
                        buttons    <= '0;
                        is_present <= 1'b0;
                    end else begin
                        buttons    <= shreg;
                        is_present <= 1'b1;
                    end
                end else begin
                    frame_err <= 1'b1;
                end
            end else if (clk_rise) begin
                shreg <= {shreg[10:0], data_s};
                if (bitcnt != 5'd31)
                    bitcnt <= bitcnt + 5'd1;
            end
        end
    end

endmodule
